// File: rtl/div_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_request_sequencer
// Description : Issues tagged divide jobs to the fixed-point divider, matches
//               each finish pulse to its job tag, and returns buffered results
//               over a valid/ready handshake. Outstanding work is bounded by
//               credits so that no divider result is ever lost.
// Revision    : 1.0 - initial release
// ============================================================================
module div_request_sequencer #(
  parameter int WIDTH = 21,
  parameter int TAG_W = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_dividend,
  input  logic [WIDTH-1:0]         req_divisor,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     div_open,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic                     div_finish,
  input  logic [WIDTH-1:0]         div_quotient,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_quotient,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_dz,
  output logic [$clog2(DEPTH):0]   credits_used,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Tag FIFO entry: {tag, dz, dividend sign}
  localparam int TW = TAG_W + 2;
  // Result FIFO entry: {quotient, tag, dz}
  localparam int RW = WIDTH + TAG_W + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW:0]   C_PTR1  = (AW+1)'(1);

  logic [TW-1:0]  tag_mem [DEPTH];
  logic [RW-1:0]  res_mem [DEPTH];
  logic [AW:0]    r_tag_wr, r_tag_rd;
  logic [AW:0]    r_res_wr, r_res_rd;
  logic [CW-1:0]  r_credits;
  logic           r_open;
  logic [WIDTH-1:0] r_dividend, r_divisor;
  logic           r_err;

  logic           w_accept;
  logic           w_tag_empty;
  logic           w_res_empty;
  logic           w_fin_ok;
  logic           w_pop;
  logic [TW-1:0]  w_tag_head;
  logic [RW-1:0]  w_res_head;
  logic [WIDTH-1:0] w_sat_q;
  logic [WIDTH-1:0] w_res_q;

  // Handshake and FIFO status decode
  assign req_ready   = (r_credits < C_DEPTH);
  assign w_accept    = req_valid & req_ready;
  assign w_tag_empty = (r_tag_wr == r_tag_rd);
  assign w_res_empty = (r_res_wr == r_res_rd);
  // A finish with nothing outstanding has no tag to pair with and is dropped
  assign w_fin_ok    = div_finish & ~w_tag_empty;
  assign res_valid   = ~w_res_empty;
  assign w_pop       = res_valid & res_ready;

  assign w_tag_head  = tag_mem[r_tag_rd[AW-1:0]];
  assign w_res_head  = res_mem[r_res_rd[AW-1:0]];

  // Zero-divisor jobs return a quotient saturated toward the dividend's sign
  assign w_sat_q = w_tag_head[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_res_q = w_tag_head[1] ? w_sat_q : div_quotient;

  // Result outputs read as zero while the buffer is empty
  assign res_quotient = w_res_empty ? '0 : w_res_head[RW-1 -: WIDTH];
  assign res_tag      = w_res_empty ? '0 : w_res_head[TAG_W:1];
  assign res_dz       = w_res_empty ? 1'b0 : w_res_head[0];

  assign div_open     = r_open;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign credits_used = r_credits;
  assign err          = r_err;

  // Tag FIFO storage: written at accept so a finish can pair with it next cycle
  always_ff @(posedge clk) begin
    if (w_accept)
      tag_mem[r_tag_wr[AW-1:0]] <= {req_tag, (req_divisor == '0), req_dividend[WIDTH-1]};
  end

  // Result FIFO storage: written when a finish pairs with a tag
  always_ff @(posedge clk) begin
    if (w_fin_ok)
      res_mem[r_res_wr[AW-1:0]] <= {w_res_q, w_tag_head[TW-1:2], w_tag_head[1]};
  end

  // Divider issue strobe and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open     <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
    end else begin
      r_open <= w_accept;
      if (w_accept) begin
        r_dividend <= req_dividend;
        r_divisor  <= req_divisor;
      end
    end
  end

  // FIFO pointers; the extra MSB separates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_wr <= '0;
      r_tag_rd <= '0;
      r_res_wr <= '0;
      r_res_rd <= '0;
    end else begin
      if (w_accept) r_tag_wr <= r_tag_wr + C_PTR1;
      if (w_fin_ok) begin
        r_tag_rd <= r_tag_rd + C_PTR1;
        r_res_wr <= r_res_wr + C_PTR1;
      end
      if (w_pop) r_res_rd <= r_res_rd + C_PTR1;
    end
  end

  // Credits count jobs in flight plus buffered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credits <= r_credits + C_ONE;
        2'b01:   r_credits <= r_credits - C_ONE;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Sticky error for an unmatched divider finish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (div_finish && w_tag_empty)
      r_err <= 1'b1;
  end

endmodule
`default_nettype wire
